// File: rtl/dap_sclk_engine.sv
// DAP probe SCLK generator: register block plus IDLE/BURST/FREE sequencer that makes SCLK and setup/sample strobes.
// Latency: burst phase 0 appears in the cycle after start; config registers take effect the cycle after the write.
// No backpressure: start is a one-cycle request, dropped while busy; status is polled through the register port.
module dap_sclk_engine #(
    parameter int ADDRWIDTH = 12,
    parameter int BASE_ADDR = 0,
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ahb_write_en,
    input  logic                 ahb_read_en,
    input  logic [ADDRWIDTH-1:0] ahb_addr,
    output logic [31:0]          ahb_rdata,
    input  logic [31:0]          ahb_wdata,
    input  logic [3:0]           ahb_byte_strobe,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] clk_count,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk_out,
    output logic                 sclk_setup,
    output logic                 sclk_sample
);

    // Phase counter is one bit wider than DIV so a full period 2*HALF never overflows.
    localparam int PW = DIV_WIDTH + 1;

    localparam logic [ADDRWIDTH-1:0] ADDR_CR     = ADDRWIDTH'(BASE_ADDR);
    localparam logic [ADDRWIDTH-1:0] ADDR_TIMING = ADDRWIDTH'(BASE_ADDR + 4);
    localparam logic [ADDRWIDTH-1:0] ADDR_STATUS = ADDRWIDTH'(BASE_ADDR + 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_FREE  = 2'd2
    } state_t;

    // Configuration registers
    logic [2:0]           cr_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] smp_q;

    // Sequencer state and registered outputs
    state_t               state_q;
    logic [PW-1:0]        phase_q;
    logic [CNT_WIDTH-1:0] rem_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 sclk_q;
    logic                 setup_q;
    logic                 smpl_q;

    logic cen;
    logic cpol;
    logic free_run;
    assign cen      = cr_q[0];
    assign cpol     = cr_q[1];
    assign free_run = cr_q[2];

    // Byte-lane views of the TIMING fields, zero-extended to 16 bits
    logic [15:0] div16_cur, smp16_cur;
    logic [15:0] div16_new, smp16_new;
    logic        wr_cr, wr_timing;
    logic        unused_hi;

    // Merge the write data into the current TIMING image lane by lane
    always_comb begin
        div16_cur                  = '0;
        smp16_cur                  = '0;
        div16_cur[DIV_WIDTH-1:0]   = div_q;
        smp16_cur[DIV_WIDTH-1:0]   = smp_q;
        div16_new[7:0]   = ahb_byte_strobe[0] ? ahb_wdata[7:0]   : div16_cur[7:0];
        div16_new[15:8]  = ahb_byte_strobe[1] ? ahb_wdata[15:8]  : div16_cur[15:8];
        smp16_new[7:0]   = ahb_byte_strobe[2] ? ahb_wdata[23:16] : smp16_cur[7:0];
        smp16_new[15:8]  = ahb_byte_strobe[3] ? ahb_wdata[31:24] : smp16_cur[15:8];
    end

    // Field bits above DIV_WIDTH are discarded on write
    assign unused_hi = ^{div16_new, smp16_new};

    assign wr_cr     = ahb_write_en && (ahb_addr == ADDR_CR);
    // TIMING is frozen while the engine is enabled so a running period never changes shape
    assign wr_timing = ahb_write_en && (ahb_addr == ADDR_TIMING) && !cen;

    // Register file writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cr_q  <= '0;
            div_q <= '0;
            smp_q <= '0;
        end else begin
            if (wr_cr && ahb_byte_strobe[0]) begin
                cr_q <= ahb_wdata[2:0];
            end
            if (wr_timing) begin
                div_q <= div16_new[DIV_WIDTH-1:0];
                smp_q <= smp16_new[DIV_WIDTH-1:0];
            end
        end
    end

    // Register read mux; anything unmapped or not enabled reads as zero
    always_comb begin
        ahb_rdata = '0;
        if (ahb_read_en) begin
            if (ahb_addr == ADDR_CR) begin
                ahb_rdata[2:0] = cr_q;
            end else if (ahb_addr == ADDR_TIMING) begin
                ahb_rdata = {smp16_cur, div16_cur};
            end else if (ahb_addr == ADDR_STATUS) begin
                ahb_rdata[8 +: CNT_WIDTH] = rem_q;
                ahb_rdata[0]              = busy_q;
            end
        end
    end

    // Waveform for a given phase: {sclk, setup, sample}
    function automatic logic [2:0] wave(input logic [PW-1:0] ph,
                                        input logic [PW-1:0] hf,
                                        input logic [PW-1:0] pl,
                                        input logic [PW-1:0] sp,
                                        input logic          pol);
        wave = {(ph >= hf) ? ~pol : pol, ph == pl, ph == sp};
    endfunction

    logic [PW-1:0] half, p_last, phase_inc, smp_ext;
    logic          at_last;
    logic [2:0]    wave_inc, wave_zero;

    // Period geometry and the strobes for the two possible next phases
    always_comb begin
        half      = (div_q == '0) ? PW'(1) : {1'b0, div_q};
        p_last    = (half << 1) - PW'(1);
        phase_inc = phase_q + PW'(1);
        smp_ext   = {1'b0, smp_q};
        // >= rather than == so a TIMING rewrite during a free-run wind-down still ends the period
        at_last   = (phase_q >= p_last);
        wave_inc  = wave(phase_inc, half, p_last, smp_ext, cpol);
        wave_zero = wave('0, half, p_last, smp_ext, cpol);
    end

    // Sequencer: outputs are registered from the phase being entered so they line up with phase_q
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            setup_q <= 1'b0;
            smpl_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cen && free_run) begin
                        state_q                    <= S_FREE;
                        phase_q                    <= '0;
                        busy_q                     <= 1'b1;
                        {sclk_q, setup_q, smpl_q}  <= wave_zero;
                    end else if (start && cen && (clk_count != '0)) begin
                        state_q                    <= S_BURST;
                        phase_q                    <= '0;
                        rem_q                      <= clk_count;
                        busy_q                     <= 1'b1;
                        {sclk_q, setup_q, smpl_q}  <= wave_zero;
                    end else begin
                        busy_q  <= 1'b0;
                        sclk_q  <= cpol;
                        setup_q <= 1'b0;
                        smpl_q  <= 1'b0;
                        // Zero-length burst completes immediately with no clocks
                        done_q  <= start && cen;
                    end
                end
                S_BURST: begin
                    if (!cen) begin
                        // Abort: drop straight to idle, no completion pulse
                        state_q <= S_IDLE;
                        phase_q <= '0;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        sclk_q  <= cpol;
                        setup_q <= 1'b0;
                        smpl_q  <= 1'b0;
                    end else if (at_last) begin
                        rem_q <= rem_q - CNT_WIDTH'(1);
                        if (rem_q == CNT_WIDTH'(1)) begin
                            state_q <= S_IDLE;
                            phase_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sclk_q  <= cpol;
                            setup_q <= 1'b0;
                            smpl_q  <= 1'b0;
                        end else begin
                            phase_q                   <= '0;
                            {sclk_q, setup_q, smpl_q} <= wave_zero;
                        end
                    end else begin
                        phase_q                   <= phase_inc;
                        {sclk_q, setup_q, smpl_q} <= wave_inc;
                    end
                end
                S_FREE: begin
                    if (at_last) begin
                        if (!cen || !free_run) begin
                            state_q <= S_IDLE;
                            phase_q <= '0;
                            busy_q  <= 1'b0;
                            sclk_q  <= cpol;
                            setup_q <= 1'b0;
                            smpl_q  <= 1'b0;
                        end else begin
                            phase_q                   <= '0;
                            {sclk_q, setup_q, smpl_q} <= wave_zero;
                        end
                    end else begin
                        phase_q                   <= phase_inc;
                        {sclk_q, setup_q, smpl_q} <= wave_inc;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    phase_q <= '0;
                    busy_q  <= 1'b0;
                    sclk_q  <= cpol;
                    setup_q <= 1'b0;
                    smpl_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sclk_out    = sclk_q;
    assign sclk_setup  = setup_q;
    assign sclk_sample = smpl_q;

endmodule

// File: tb/tb_dap_sclk_engine.sv
// Scoreboard bench for dap_sclk_engine: per-cycle expected outputs are queued with the stimulus.
// Cycle c0 is the cycle in which the scenario's first stimulus is driven; outputs are sampled on the falling edge.
// A register write driven in cycle n is visible in the register from cycle n+1.
module tb_dap_sclk_engine;

    localparam logic [11:0] A_CR  = 12'h000;
    localparam logic [11:0] A_TIM = 12'h004;
    localparam logic [11:0] A_ST  = 12'h008;
    localparam logic [11:0] A_BAD = 12'h00C;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ahb_write_en = 1'b0;
    logic        ahb_read_en = 1'b0;
    logic [11:0] ahb_addr = '0;
    logic [31:0] ahb_rdata;
    logic [31:0] ahb_wdata = '0;
    logic [3:0]  ahb_byte_strobe = '0;
    logic        start = 1'b0;
    logic [7:0]  clk_count = '0;
    logic        busy, done, sclk_out, sclk_setup, sclk_sample;

    dap_sclk_engine #(
        .ADDRWIDTH(12), .BASE_ADDR(0), .DIV_WIDTH(16), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ahb_write_en(ahb_write_en), .ahb_read_en(ahb_read_en),
        .ahb_addr(ahb_addr), .ahb_rdata(ahb_rdata), .ahb_wdata(ahb_wdata),
        .ahb_byte_strobe(ahb_byte_strobe),
        .start(start), .clk_count(clk_count),
        .busy(busy), .done(done), .sclk_out(sclk_out),
        .sclk_setup(sclk_setup), .sclk_sample(sclk_sample)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy; logic done; logic sclk; logic setup; logic sample;
    } obs_t;

    typedef struct packed {
        logic start; logic [7:0] cnt; logic wr; logic [2:0] cr;
    } stim_t;

    obs_t  exp_q[$];
    stim_t stim_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    smp_seen = 0;

    // ---------------- expectation builders (spec model) ----------------
    task automatic push_idle(input int n, input logic cpol);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = '0; e.sclk = cpol;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input logic cpol);
        obs_t e;
        e = '0; e.done = 1'b1; e.sclk = cpol;
        exp_q.push_back(e);
    endtask

    task automatic push_active(input int n, input int half, input int smp, input logic cpol);
        obs_t e;
        int   p, ph;
        p = 2 * half;
        for (int k = 0; k < n; k++) begin
            ph       = k % p;
            e        = '0;
            e.busy   = 1'b1;
            e.sclk   = (ph < half) ? cpol : ~cpol;
            e.setup  = (ph == p - 1);
            e.sample = (ph == smp);
            exp_q.push_back(e);
        end
    endtask

    task automatic set_stim(input int c, input logic st, input logic [7:0] n,
                            input logic w, input logic [2:0] cr);
        stim_t s;
        while (stim_q.size() <= c) stim_q.push_back('0);
        s.start = st; s.cnt = n; s.wr = w; s.cr = cr;
        stim_q[c] = s;
    endtask

    // Apply queued stimulus cycle by cycle and compare against the popped expectation
    task automatic play(input string name);
        stim_t s;
        obs_t  e, o;
        int    cyc;
        cyc = 0;
        smp_seen = 0;
        while (exp_q.size() > 0) begin
            s = '0;
            if (stim_q.size() > 0) s = stim_q.pop_front();
            start           = s.start;
            clk_count       = s.cnt;
            ahb_write_en    = s.wr;
            ahb_addr        = A_CR;
            ahb_wdata       = {29'd0, s.cr};
            ahb_byte_strobe = 4'hF;
            @(negedge clk);
            e = exp_q.pop_front();
            o = {busy, done, sclk_out, sclk_setup, sclk_sample};
            if (sclk_sample === 1'b1) smp_seen++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s c%0d: {busy,done,sclk,setup,sample} got %b want %b", name, cyc, o, e);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; ahb_write_en = 1'b0; ahb_byte_strobe = '0;
        stim_q.delete();
    endtask

    // ---------------- bus helpers ----------------
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        ahb_write_en = 1'b1; ahb_addr = a; ahb_wdata = d; ahb_byte_strobe = s;
        @(posedge clk); #1;
        ahb_write_en = 1'b0; ahb_byte_strobe = '0;
    endtask

    task automatic rd(input logic [11:0] a, input logic en, output logic [31:0] d);
        ahb_read_en = en; ahb_addr = a;
        #1;
        d = ahb_rdata;
        ahb_read_en = 1'b0;
    endtask

    task automatic configure(input logic [15:0] div, input logic [15:0] smp, input logic cpol);
        wr(A_CR, 32'h0, 4'hF);
        wr(A_TIM, {smp, div}, 4'hF);
        wr(A_CR, {29'd0, 1'b0, cpol, 1'b1}, 4'hF);
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        obs_t o;
        @(negedge clk);
        o = {busy, done, sclk_out, sclk_setup, sclk_sample};
        vectors++;
        if (o !== 5'b0) begin
            miscompares++; $display("FAIL reset_outputs: got %b want 00000", o);
        end
        rd(A_CR, 1'b1, d);  vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_cr: got %h want 0", d); end
        rd(A_TIM, 1'b1, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_timing: got %h want 0", d); end
        rd(A_ST, 1'b1, d);  vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h want 0", d); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_regs();
        logic [31:0] d;
        wr(A_CR, 32'h0, 4'hF);
        wr(A_TIM, 32'h0009_0002, 4'hF);
        wr(A_TIM, 32'h1234_5678, 4'b0010);
        rd(A_TIM, 1'b1, d); vectors++;
        if (d !== 32'h0009_5602) begin miscompares++; $display("FAIL strobe_timing: got %h want 00095602", d); end
        wr(A_CR, 32'h0000_0007, 4'b1110);
        rd(A_CR, 1'b1, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL strobe_cr_masked: got %h want 0", d); end
        wr(A_CR, 32'hFFFF_FFFA, 4'b0001);
        rd(A_CR, 1'b1, d); vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL cr_reserved_bits: got %h want 2", d); end
        rd(A_BAD, 1'b1, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_read: got %h want 0", d); end
        rd(A_TIM, 1'b0, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL read_disabled: got %h want 0", d); end
        wr(A_CR, 32'h0, 4'hF);
        @(posedge clk); #1;
    endtask

    task automatic test_burst(input string name, input int div, input int smp,
                              input logic cpol, input int count);
        int half, p, want;
        configure(div[15:0], smp[15:0], cpol);
        half = (div == 0) ? 1 : div;
        p    = 2 * half;
        set_stim(0, 1'b1, count[7:0], 1'b0, 3'b000);
        push_idle(1, cpol);
        push_active(count * p, half, smp, cpol);
        push_done(cpol);
        push_idle(2, cpol);
        play(name);
        want = (smp < p) ? count : 0;
        vectors++;
        if (smp_seen !== want) begin
            miscompares++; $display("FAIL %s_sample_count: got %0d want %0d", name, smp_seen, want);
        end
    endtask

    task automatic test_abort();
        configure(16'd2, 16'd1, 1'b0);
        set_stim(0, 1'b1, 8'd3, 1'b0, 3'b000);
        set_stim(4, 1'b0, 8'd0, 1'b1, 3'b000);   // CEN reads 0 from c5
        push_idle(1, 1'b0);
        push_active(5, 2, 1, 1'b0);
        push_idle(6, 1'b0);
        play("abort");
    endtask

    task automatic test_cen_locked();
        logic [31:0] d;
        configure(16'd2, 16'd9, 1'b0);
        wr(A_TIM, 32'h0003_0004, 4'hF);
        rd(A_TIM, 1'b1, d); vectors++;
        if (d !== 32'h0009_0002) begin miscompares++; $display("FAIL timing_locked: got %h want 00090002", d); end
        set_stim(0, 1'b1, 8'd0, 1'b0, 3'b000);
        push_idle(1, 1'b0);
        push_done(1'b0);
        push_idle(2, 1'b0);
        play("zero_count");
    endtask

    task automatic test_disabled();
        wr(A_CR, 32'h0, 4'hF);
        @(posedge clk); #1;
        set_stim(0, 1'b1, 8'd3, 1'b0, 3'b000);
        push_idle(4, 1'b0);
        play("start_no_cen");
    endtask

    task automatic test_back_to_back();
        configure(16'd1, 16'd1, 1'b0);
        set_stim(0, 1'b1, 8'd1, 1'b0, 3'b000);
        set_stim(1, 1'b1, 8'd4, 1'b0, 3'b000);   // busy: ignored
        set_stim(3, 1'b1, 8'd2, 1'b0, 3'b000);   // in the done cycle: accepted
        push_idle(1, 1'b0);
        push_active(2, 1, 1, 1'b0);
        push_done(1'b0);
        push_active(4, 1, 1, 1'b0);
        push_done(1'b0);
        push_idle(1, 1'b0);
        play("back_to_back");
    endtask

    task automatic test_free_run();
        wr(A_CR, 32'h0, 4'hF);
        wr(A_TIM, 32'h0000_0001, 4'hF);
        @(posedge clk); #1;
        set_stim(0,  1'b0, 8'd0, 1'b1, 3'b101);  // FREE_RUN|CEN visible c1, FREE from c2
        set_stim(4,  1'b1, 8'd5, 1'b0, 3'b000);  // ignored while free-running
        set_stim(11, 1'b0, 8'd0, 1'b1, 3'b001);  // FREE_RUN clear visible c12, period ends c13
        push_idle(2, 1'b0);
        push_active(12, 1, 0, 1'b0);
        push_idle(3, 1'b0);
        play("free_run");
        vectors++;
        if (smp_seen !== 6) begin
            miscompares++; $display("FAIL free_run_samples: got %0d want 6", smp_seen);
        end
        wr(A_CR, 32'h0, 4'hF);
    endtask

    task automatic test_status();
        logic [31:0] d;
        logic        seen;
        configure(16'd1, 16'd0, 1'b0);
        start = 1'b1; clk_count = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        rd(A_ST, 1'b1, d); vectors++;
        if (d !== 32'h0000_0501) begin miscompares++; $display("FAIL status_running: got %h want 00000501", d); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        vectors++;
        if (seen !== 1'b1) begin miscompares++; $display("FAIL status_done_timeout: got %b want 1", seen); end
        rd(A_ST, 1'b1, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL status_after_done: got %h want 0", d); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d;
        obs_t o;
        configure(16'd2, 16'd1, 1'b1);
        start = 1'b1; clk_count = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_burst_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        o = {busy, done, sclk_out, sclk_setup, sclk_sample};
        vectors++;
        if (o !== 5'b0) begin miscompares++; $display("FAIL async_reset_outputs: got %b want 00000", o); end
        rd(A_CR, 1'b1, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL async_reset_cr: got %h want 0", d); end
        rd(A_TIM, 1'b1, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL async_reset_timing: got %h want 0", d); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        o = {busy, done, sclk_out, sclk_setup, sclk_sample};
        vectors++;
        if (o !== 5'b0) begin miscompares++; $display("FAIL post_reset_idle: got %b want 00000", o); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_regs();
        test_burst("burst_div2", 2, 1, 1'b0, 3);
        test_burst("burst_div0_cpol", 0, 0, 1'b1, 2);
        test_burst("burst_no_sample", 2, 9, 1'b0, 2);
        test_abort();
        test_cen_locked();
        test_disabled();
        test_back_to_back();
        test_free_run();
        test_status();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
